// File: rtl/fifo_arb_ctrl.sv
// Two-requester round-robin write arbiter in front of a FIFO controller that
// drives an external synchronous dual-port memory (read data one clock late).
module fifo_arb_ctrl #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int AF_TH = 240
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic          flush,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          rd_udf,
    output logic          mem_w_en,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_data,
    output logic [AW-1:0] mem_r_addr,
    input  logic [DW-1:0] mem_r_data
);

    localparam logic [AW:0] DEPTH  = (AW+1)'(1) << AW;
    localparam logic [AW:0] AF_LVL = AF_TH[AW:0];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          last_gnt;
    logic          grant;
    logic          pop;

    assign full        = (count == DEPTH);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_LVL);

    // rst_n gates the grant so nothing is accepted while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !full && !flush) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign grant      = gnt0 | gnt1;
    assign pop        = rd_en && !empty && !flush;
    assign mem_w_en   = grant;
    assign mem_w_addr = wr_ptr;
    assign mem_w_data = gnt1 ? data1 : data0;
    assign mem_r_addr = rd_ptr;
    assign dout       = mem_r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_gnt   <= 1'b1;
            dout_valid <= 1'b0;
            rd_udf     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            dout_valid <= pop;
            if (grant) begin
                last_gnt <= gnt1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                rd_udf <= 1'b0;
            end else begin
                if (grant) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({grant, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (rd_en && empty) begin
                    rd_udf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Self-checking bench for fifo_arb_ctrl: arbitration vector table, scoreboard
// on read data, and hand-written sequences for full, underflow, flush and reset.
module tb_fifo_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, flush, rd_en;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1;
    logic [7:0] dout;
    logic       dout_valid, full, empty, almost_full, rd_udf;
    logic [8:0] count;
    logic       mem_w_en;
    logic [7:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [7:0] sb[$];
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    fifo_arb_ctrl #(.AW(8), .DW(8), .AF_TH(240)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .flush(flush), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .rd_udf(rd_udf),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
    );

    // Synchronous memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        mem_r_data <= mem[mem_r_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dout_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dout_unexpected: got %0h with no word expected at %0t", dout, $time);
            end else begin
                check("dout", 32'(dout), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r0, r1;
        logic [7:0] d0, d1;
        logic       g0, g1;
        logic [7:0] addr, wdata;
        logic [8:0] cnt;
    } vec_t;

    vec_t tbl[9];
    int   p0;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 8'hA0, 8'hB0, 1'b1, 1'b0, 8'd0, 8'hA0, 9'd1};
        tbl[1] = '{1'b1, 1'b1, 8'hA1, 8'hB1, 1'b0, 1'b1, 8'd1, 8'hB1, 9'd2};
        tbl[2] = '{1'b1, 1'b1, 8'hA2, 8'hB2, 1'b1, 1'b0, 8'd2, 8'hA2, 9'd3};
        tbl[3] = '{1'b1, 1'b1, 8'hA3, 8'hB3, 1'b0, 1'b1, 8'd3, 8'hB3, 9'd4};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hC4, 1'b0, 1'b1, 8'd4, 8'hC4, 9'd5};
        tbl[5] = '{1'b1, 1'b1, 8'hD5, 8'hE5, 1'b1, 1'b0, 8'd5, 8'hD5, 9'd6};
        tbl[6] = '{1'b1, 1'b0, 8'hF6, 8'h00, 1'b1, 1'b0, 8'd6, 8'hF6, 9'd7};
        tbl[7] = '{1'b1, 1'b1, 8'h17, 8'h27, 1'b0, 1'b1, 8'd7, 8'h27, 9'd8};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00, 9'd8};

        // Reset state, with requests asserted to show they are not honoured.
        rst_n = 1'b0; flush = 1'b0; rd_en = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h00; data1 = 8'h00;
        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_wen", 32'(mem_w_en), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        check("rst_udf", 32'(rd_udf), 32'd0);
        repeat (2) @(posedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Arbitration table: round-robin, single requesters, idle.
        for (int i = 0; i < 9; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; data0 = tbl[i].d0; data1 = tbl[i].d1;
            #1;
            check($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            check($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            check($sformatf("tbl%0d_wen", i), 32'(mem_w_en), 32'(tbl[i].g0 | tbl[i].g1));
            if (tbl[i].g0 | tbl[i].g1) begin
                check($sformatf("tbl%0d_addr", i), 32'(mem_w_addr), 32'(tbl[i].addr));
                check($sformatf("tbl%0d_wdata", i), 32'(mem_w_data), 32'(tbl[i].wdata));
                sb.push_back(tbl[i].wdata);
            end
            tick();
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
        end
        req0 = 1'b0; req1 = 1'b0;

        // Drain the eight entries; scoreboard checks memory contents and order.
        rd_en = 1'b1;
        repeat (8) tick();
        rd_en = 1'b0;
        tick();
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_udf", 32'(rd_udf), 32'd0);

        // Single write then three reads: one pulse, sticky underflow.
        p0 = pulses;
        req0 = 1'b1; data0 = 8'h5A;
        sb.push_back(8'h5A);
        tick();
        req0 = 1'b0; rd_en = 1'b1;
        tick();
        check("udf_after_pop", 32'(rd_udf), 32'd0);
        check("dv_after_pop", 32'(dout_valid), 32'd1);
        tick();
        check("udf_2nd_read", 32'(rd_udf), 32'd1);
        tick();
        check("udf_3rd_read", 32'(rd_udf), 32'd1);
        check("udf_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;
        tick();
        check("udf_sticky", 32'(rd_udf), 32'd1);
        check("one_pulse", 32'(pulses - p0), 32'd1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_udf", 32'(rd_udf), 32'd0);

        // Fill to full with req0, check almost_full threshold and full blocking.
        req0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            data0 = 8'(i);
            #1;
            check($sformatf("fill%0d_gnt0", i), 32'(gnt0), 32'd1);
            check($sformatf("fill%0d_af", i), 32'(almost_full), 32'(i >= 240));
            sb.push_back(8'(i));
            tick();
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd256);
        #1;
        check("full_gnt0_257", 32'(gnt0), 32'd0);
        tick();
        check("full_count_257", 32'(count), 32'd256);

        // While full, a read proceeds and the write waits one cycle.
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h77; rd_en = 1'b1;
        #1;
        check("full_rd_gnt1", 32'(gnt1), 32'd0);
        tick();
        check("full_rd_count", 32'(count), 32'd255);
        rd_en = 1'b0;
        #1;
        check("after_rd_gnt1", 32'(gnt1), 32'd1);
        check("wrap_addr", 32'(mem_w_addr), 32'd0);
        sb.push_back(8'h77);
        tick();
        check("after_rd_count", 32'(count), 32'd256);
        req1 = 1'b0;

        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();

        // Flush overrides grant and pop; a pop just before it still shows.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pre_flush_udf", 32'(rd_udf), 32'd1);
        req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data0 = 8'h30 + 8'(i);
            sb.push_back(data0);
            tick();
        end
        req0 = 1'b0;
        check("ten_count", 32'(count), 32'd10);
        rd_en = 1'b1;
        tick();
        flush = 1'b1; req0 = 1'b1;
        #1;
        check("flush_gnt0", 32'(gnt0), 32'd0);
        check("flush_wen", 32'(mem_w_en), 32'd0);
        check("flush_dv_prev_pop", 32'(dout_valid), 32'd1);
        tick();
        sb.delete();
        flush = 1'b0; req0 = 1'b0; rd_en = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_udf2", 32'(rd_udf), 32'd0);
        check("flush_dv", 32'(dout_valid), 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("flush_keeps_last_gnt", 32'(gnt1), 32'd1);
        tick();

        // Asynchronous reset mid-burst.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("arst_wen", 32'(mem_w_en), 32'd0);
        check("arst_dv", 32'(dout_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_gnt0", 32'(gnt0), 32'd1);
        check("post_rst_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
